// File: rtl/mdu_ctrl_if.sv
// Pipeline-facing bundle of the multiply/divide unit: E/D-stage opcodes and
// operands in, handshake status plus the HI/LO view out.
interface mdu_ctrl_if;
  logic [3:0]  e_mdOp;
  logic        e_valid;
  logic [3:0]  d_mdOp;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output e_mdOp, e_valid, d_mdOp, rs_val, rt_val,
    input  start, busy, stall_req, md_out, hi, lo
  );

  modport slave (
    input  e_mdOp, e_valid, d_mdOp, rs_val, rt_val,
    output start, busy, stall_req, md_out, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the architectural HI/LO pair.
// Define MDU_DIV_EN to build the divider; without it div/divu are ignored.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic   clk,
  input  logic   reset_n,
  mdu_ctrl_if.slave md
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        hi_q, lo_q, hi_nxt, lo_nxt;
  logic [31:0]        hi_p, lo_p, hi_p_nxt, lo_p_nxt;
  logic               commit_ok, commit_ok_nxt;
  logic               is_mul, is_div;
  logic [63:0]        prod;

  assign is_mul = (md.e_mdOp == 4'd1) || (md.e_mdOp == 4'd2);

  // Sign-extending both operands makes the low 64 bits of an unsigned
  // multiply equal the signed product, so one multiplier serves both ops.
  always_comb begin
    if (md.e_mdOp == 4'd1)
      prod = {{32{md.rs_val[31]}}, md.rs_val} * {{32{md.rt_val[31]}}, md.rt_val};
    else
      prod = {32'd0, md.rs_val} * {32'd0, md.rt_val};
  end

`ifdef MDU_DIV_EN
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign is_div = (md.e_mdOp == 4'd3) || (md.e_mdOp == 4'd4);

  // Magnitude division with sign fix-up: quotient truncates toward zero and
  // the remainder follows the dividend; a zero divisor is replaced to keep
  // the datapath defined, and the commit is suppressed instead.
  always_comb begin
    a_neg  = (md.e_mdOp == 4'd3) && md.rs_val[31];
    b_neg  = (md.e_mdOp == 4'd3) && md.rt_val[31];
    a_mag  = a_neg ? (32'd0 - md.rs_val) : md.rs_val;
    b_mag  = b_neg ? (32'd0 - md.rt_val) : md.rt_val;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end
`else
  assign is_div = 1'b0;
`endif

  assign md.start     = reset_n && md.e_valid && (is_mul || is_div) && (state == IDLE);
  assign md.busy      = (state != IDLE);
  assign md.stall_req = (md.d_mdOp != 4'd0) && (md.start || md.busy);
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;

  always_comb begin
    md.md_out = 32'd0;
    if (md.e_mdOp == 4'd7)
      md.md_out = hi_q;
    else if (md.e_mdOp == 4'd8)
      md.md_out = lo_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_p      <= 32'd0;
      lo_p      <= 32'd0;
      commit_ok <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi_q      <= hi_nxt;
      lo_q      <= lo_nxt;
      hi_p      <= hi_p_nxt;
      lo_p      <= lo_p_nxt;
      commit_ok <= commit_ok_nxt;
    end
  end

  // Results wait in hi_p/lo_p until the countdown expires; anything arriving
  // on e_mdOp while busy falls through to the defaults and is ignored.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_nxt        = hi_q;
    lo_nxt        = lo_q;
    hi_p_nxt      = hi_p;
    lo_p_nxt      = lo_p;
    commit_ok_nxt = commit_ok;
    unique case (state)
      IDLE: begin
        if (md.start && is_mul) begin
          {hi_p_nxt, lo_p_nxt} = prod;
          commit_ok_nxt        = 1'b1;
          cnt_nxt              = CNT_W'(MUL_CYCLES - 1);
          state_nxt            = MUL;
        end
`ifdef MDU_DIV_EN
        else if (md.start && is_div) begin
          hi_p_nxt      = rem;
          lo_p_nxt      = quot;
          commit_ok_nxt = (md.rt_val != 32'd0);
          cnt_nxt       = CNT_W'(DIV_CYCLES - 1);
          state_nxt     = DIV;
        end
`endif
        else if (md.e_valid && (md.e_mdOp == 4'd5))
          hi_nxt = md.rs_val;
        else if (md.e_valid && (md.e_mdOp == 4'd6))
          lo_nxt = md.rs_val;
      end
      MUL, DIV: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          if (commit_ok) begin
            hi_nxt = hi_p;
            lo_nxt = lo_p;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
